control_cmd_watchdog_tx: RTL and testbench



---
 rtl/control_cmd_watchdog_tx_pkg.sv | 15 +
 rtl/control_cmd_watchdog_tx_if.sv | 12 +
 rtl/control_cmd_watchdog_tx_tick_interval_counter.sv | 28 ++
 rtl/control_cmd_watchdog_tx.sv | 109 ++++++++++
 tb/tb_control_cmd_watchdog_tx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/control_cmd_watchdog_tx_pkg.sv
// Shared parameters and state encoding for the watchdog signature transmitter.
// Pure declarations: no latency, no flow control.
package control_cmd_watchdog_tx_pkg;

    localparam int WATCHDOG_SIGNATURE_BITS = 32;
    localparam logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = 32'hDEADBEEF;
    localparam int WATCHDOG_HEARTBEAT_TICKS = 4;

    typedef enum logic [1:0] {
        WDT_TX_IDLE,
        WDT_TX_SEND,
        WDT_TX_DONE
    } wdt_tx_state_t;

endpackage

// File: rtl/control_cmd_watchdog_tx_if.sv
// Byte stream link carrying the signature from transmitter to a byte sink.
// The master holds tx_data/tx_valid steady until the slave raises tx_ready.
interface control_cmd_watchdog_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/control_cmd_watchdog_tx_tick_interval_counter.sv
// Tick-gated modulo counter; terminal is combinational in the tick cycle that wraps it.
// No flow control: counting freezes while en=0, clear wins over counting.
module control_cmd_watchdog_tx_tick_interval_counter #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic tick,
    output logic terminal
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] cnt;

    assign terminal = en && tick && (cnt == CW'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en && tick) begin
            cnt <= terminal ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/control_cmd_watchdog_tx.sv
// Sends the watchdog signature MSB byte first, on heartbeat expiry or send_now; first byte 1 clk after request.
// Bytes wait on tx_ready without changing; requests arriving mid-frame coalesce into one follow-up frame.
module control_cmd_watchdog_tx #(
    parameter int WATCHDOG_SIGNATURE_BITS = control_cmd_watchdog_tx_pkg::WATCHDOG_SIGNATURE_BITS,
    parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN =
        control_cmd_watchdog_tx_pkg::WATCHDOG_SIGNATURE_PATTERN,
    parameter int HEARTBEAT_TICKS = control_cmd_watchdog_tx_pkg::WATCHDOG_HEARTBEAT_TICKS,
    parameter int _UNUSED = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       auto_en,
    input  logic                       send_now,
    control_cmd_watchdog_tx_if.master  tx,
    output logic                       busy,
    output logic                       frame_done
);

    import control_cmd_watchdog_tx_pkg::*;

    localparam int NBYTES = WATCHDOG_SIGNATURE_BITS / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if ((WATCHDOG_SIGNATURE_BITS < 8) || (WATCHDOG_SIGNATURE_BITS % 8 != 0)) begin : g_bad_bits
        $error("WATCHDOG_SIGNATURE_BITS must be a positive multiple of 8");
    end
    if (HEARTBEAT_TICKS < 1) begin : g_bad_ticks
        $error("HEARTBEAT_TICKS must be at least 1");
    end

    function automatic logic [7:0] sig_byte(input int k);
        return WATCHDOG_SIGNATURE_PATTERN[8*(NBYTES-1-k) +: 8];
    endfunction

    wdt_tx_state_t  state;
    logic [IW-1:0]  idx;
    logic           pending;
    logic           hb_fire;
    logic           start_req;
    logic           idle;

    assign idle      = (state == WDT_TX_IDLE);
    assign start_req = send_now || hb_fire || pending;

    // The heartbeat only advances while idle, so it can never fire mid-frame.
    control_cmd_watchdog_tx_tick_interval_counter #(
        .TICKS (HEARTBEAT_TICKS)
    ) u_heartbeat (
        .clk      (clk),
        .reset    (reset),
        .clear    (idle && start_req),
        .en       (auto_en && idle),
        .tick     (tick),
        .terminal (hb_fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WDT_TX_IDLE;
            tx.tx_data  <= 8'h00;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            idx         <= '0;
            pending     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WDT_TX_IDLE: begin
                    if (start_req) begin
                        state       <= WDT_TX_SEND;
                        tx.tx_valid <= 1'b1;
                        tx.tx_data  <= sig_byte(0);
                        idx         <= '0;
                        busy        <= 1'b1;
                        pending     <= 1'b0;
                    end
                end
                WDT_TX_SEND: begin
                    if (send_now) pending <= 1'b1;
                    if (tx.tx_valid && tx.tx_ready) begin
                        if (idx == IW'(NBYTES - 1)) begin
                            state       <= WDT_TX_DONE;
                            tx.tx_valid <= 1'b0;
                            tx.tx_data  <= 8'h00;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                        end else begin
                            idx        <= idx + 1'b1;
                            tx.tx_data <= sig_byte(int'(idx) + 1);
                        end
                    end
                end
                WDT_TX_DONE: begin
                    if (send_now) pending <= 1'b1;
                    state <= WDT_TX_IDLE;
                end
                default: begin
                    state       <= WDT_TX_IDLE;
                    tx.tx_valid <= 1'b0;
                    tx.tx_data  <= 8'h00;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_cmd_watchdog_tx.sv
// Directed bench for control_cmd_watchdog_tx with a 32-bit DEADBEEF signature and 4-tick heartbeat.
module tb_control_cmd_watchdog_tx;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic auto_en;
    logic send_now;
    logic busy;
    logic frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    control_cmd_watchdog_tx_if ifc ();

    control_cmd_watchdog_tx #(
        .WATCHDOG_SIGNATURE_BITS    (32),
        .WATCHDOG_SIGNATURE_PATTERN (32'hDEADBEEF),
        .HEARTBEAT_TICKS            (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .auto_en    (auto_en),
        .send_now   (send_now),
        .tx         (ifc),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic out(input string tag, input logic v, input logic [7:0] d,
                       input logic b, input logic fd);
        chk({tag, ".valid"}, 32'(ifc.tx_valid), 32'(v));
        chk({tag, ".data"},  32'(ifc.tx_data),  32'(d));
        chk({tag, ".busy"},  32'(busy),         32'(b));
        chk({tag, ".done"},  32'(frame_done),   32'(fd));
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic b, input logic fd);
        out(tag, v, d, b, fd);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int cyc;
        int nv;

        reset = 1'b1; tick = 1'b0; auto_en = 1'b0; send_now = 1'b0; ifc.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out("reset", 1'b0, 8'h00, 1'b0, 1'b0);

        // Basic frame with the sink always ready.
        send_now = 1'b1; @(negedge clk); send_now = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("basic%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
        step("basic_done", 1'b0, 8'h00, 1'b0, 1'b1);
        step("basic_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        send_now = 1'b1; ifc.tx_ready = 1'b0; @(negedge clk); send_now = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            ifc.tx_ready = (cyc % 3 == 0);
            chk("bp_valid", 32'(ifc.tx_valid), 32'd1);
            chk($sformatf("bp_data%0d", k), 32'(ifc.tx_data), 32'(exp_b[k]));
            if (ifc.tx_valid && ifc.tx_ready) k++;
            @(negedge clk);
            cyc++;
        end
        chk("bp_count", 32'(k), 32'd4);
        chk("bp_cycles", 32'(cyc), 32'd10);
        ifc.tx_ready = 1'b1;
        step("bp_done", 1'b0, 8'h00, 1'b0, 1'b1);
        step("bp_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Three requests during a frame yield exactly one more frame after a 2-cycle gap.
        send_now = 1'b1; @(negedge clk);
        for (int i = 0; i < 3; i++) step($sformatf("co_a%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
        send_now = 1'b0;
        step("co_a3", 1'b1, exp_b[3], 1'b1, 1'b0);
        step("co_done_a", 1'b0, 8'h00, 1'b0, 1'b1);
        step("co_gap", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("co_b%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
        step("co_done_b", 1'b0, 8'h00, 1'b0, 1'b1);
        nv = 0;
        repeat (6) begin
            if (ifc.tx_valid) nv++;
            @(negedge clk);
        end
        chk("co_no_third", 32'(nv), 32'd0);

        // Reset after the second byte is accepted aborts the frame.
        send_now = 1'b1; @(negedge clk); send_now = 1'b0;
        step("rm0", 1'b1, 8'hDE, 1'b1, 1'b0);
        step("rm1", 1'b1, 8'hAD, 1'b1, 1'b0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        out("rm_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        step("rm_quiet", 1'b0, 8'h00, 1'b0, 1'b0);
        send_now = 1'b1; @(negedge clk); send_now = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("rm_re%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
        step("rm_re_done", 1'b0, 8'h00, 1'b0, 1'b1);

        // Heartbeat: every 4th tick launches a frame one clock later.
        auto_en = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            chk($sformatf("hb_valid_t%0d", t), 32'(ifc.tx_valid), 32'((t % 4) == 0));
            if (t % 4 == 0) chk($sformatf("hb_data_t%0d", t), 32'(ifc.tx_data), 32'hDE);
            repeat (15) @(negedge clk);
        end

        // Counter holds across auto_en=0: 2 ticks, 20 disabled ticks, then 2 more ticks.
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            repeat (15) @(negedge clk);
        end
        auto_en = 1'b0;
        nv = 0;
        for (int t = 0; t < 20; t++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            if (ifc.tx_valid) nv++;
            repeat (15) begin
                @(negedge clk);
                if (ifc.tx_valid) nv++;
            end
        end
        chk("hb_disabled_frames", 32'(nv), 32'd0);
        auto_en = 1'b1;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        chk("hb_hold_third", 32'(ifc.tx_valid), 32'd0);
        repeat (15) @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        chk("hb_hold_fourth", 32'(ifc.tx_valid), 32'd1);
        repeat (15) @(negedge clk);

        // Heartbeat expiry together with send_now starts a single frame.
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            repeat (15) @(negedge clk);
        end
        tick = 1'b1; send_now = 1'b1; @(negedge clk); tick = 1'b0; send_now = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("sim%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
        step("sim_done", 1'b0, 8'h00, 1'b0, 1'b1);
        nv = 0;
        repeat (6) begin
            if (ifc.tx_valid) nv++;
            @(negedge clk);
        end
        chk("sim_single", 32'(nv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
